// File: rtl/secuenciador_bandas_if.sv
// ---------------------------------------------------------------------------
// secuenciador_bandas_if
// Handshake bundle between the band sequencer, the ADC front end and the
// shared filter engine.
//   adc_inicio / adc_listo / salidaADC        : ADC conversion handshake
//   filtro_inicio / filtro_banda / filtro_entrada
//   filtro_fin / filtro_salida                : shared filter handshake
//   salida_mezcla / salida_valida             : mixed sample to the DAC stage
//   sobrecarga                                : sticky missed-tick flag
// master : sequencer view (drives the start pulses and results)
// slave  : environment view (ADC, filter engine, output stage)
// ---------------------------------------------------------------------------
interface secuenciador_bandas_if #(
    parameter int ANCHO = 23
);
    logic                    adc_inicio;
    logic                    adc_listo;
    logic [11:0]             salidaADC;
    logic                    filtro_inicio;
    logic [1:0]              filtro_banda;
    logic signed [ANCHO-1:0] filtro_entrada;
    logic                    filtro_fin;
    logic signed [ANCHO-1:0] filtro_salida;
    logic signed [ANCHO-1:0] salida_mezcla;
    logic                    salida_valida;
    logic                    sobrecarga;

    modport master (
        output adc_inicio,
        input  adc_listo,
        input  salidaADC,
        output filtro_inicio,
        output filtro_banda,
        output filtro_entrada,
        input  filtro_fin,
        input  filtro_salida,
        output salida_mezcla,
        output salida_valida,
        output sobrecarga
    );

    modport slave (
        input  adc_inicio,
        output adc_listo,
        output salidaADC,
        input  filtro_inicio,
        input  filtro_banda,
        input  filtro_entrada,
        output filtro_fin,
        output filtro_salida,
        input  salida_mezcla,
        input  salida_valida,
        input  sobrecarga
    );
endinterface

// File: rtl/secuenciador_bandas.sv
// ---------------------------------------------------------------------------
// secuenciador_bandas
// Sample-rate controller for the equalizer datapath. A free-running divider
// paces ADC conversions; each 12-bit unsigned ADC word is re-centred into the
// signed filter format, run through the shared filter once per band, and the
// band results are summed and clamped into one mixed sample.
//
// Ports
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high
//   bus    : secuenciador_bandas_if.master (ADC, filter and output handshakes)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ESPERA    | idle, waiting for the next sample tick
// CONVIERTE | ADC started, waiting for adc_listo
// AGUARDA   | filter running on band k, waiting for filtro_fin
// ---------------------------------------------------------------------------
module secuenciador_bandas #(
    parameter int N_BANDAS     = 3,
    parameter int ANCHO        = 23,
    parameter int DIV_MUESTREO = 2268
) (
    input  logic                  clk,
    input  logic                  reset,
    secuenciador_bandas_if.master bus
);

    localparam int ANCHO_CNT = (DIV_MUESTREO > 1) ? $clog2(DIV_MUESTREO) : 1;
    localparam logic [ANCHO_CNT-1:0] CNT_ULT   = ANCHO_CNT'(DIV_MUESTREO - 1);
    localparam logic [1:0]           BANDA_ULT = 2'(N_BANDAS - 1);
    localparam logic [ANCHO-1:0]     OFFSET_ADC = ANCHO'(8192);
    // Accumulator has two guard bits so up to four full-scale bands never wrap.
    localparam logic signed [ANCHO+1:0] SAT_MAX = {3'b000, {(ANCHO-1){1'b1}}};
    localparam logic signed [ANCHO+1:0] SAT_MIN = {3'b111, {(ANCHO-1){1'b0}}};

    typedef enum logic [1:0] {
        ESPERA    = 2'd0,
        CONVIERTE = 2'd1,
        AGUARDA   = 2'd2
    } estado_t;

    estado_t                 estado_q, estado_d;
    logic [ANCHO_CNT-1:0]    cnt_q, cnt_d;
    logic [1:0]              k_q, k_d;
    logic signed [ANCHO+1:0] acc_q, acc_d;
    logic signed [ANCHO+1:0] suma;
    logic signed [ANCHO-1:0] entrada_q, entrada_d;
    logic signed [ANCHO-1:0] mezcla_q, mezcla_d;
    logic                    adc_inicio_q, adc_inicio_d;
    logic                    filtro_inicio_q, filtro_inicio_d;
    logic                    valida_q, valida_d;
    logic                    sobre_q, sobre_d;
    logic                    tick;

    assign tick = (cnt_q == CNT_ULT);

    always_comb begin
        cnt_d           = tick ? '0 : cnt_q + ANCHO_CNT'(1);
        estado_d        = estado_q;
        k_d             = k_q;
        acc_d           = acc_q;
        entrada_d       = entrada_q;
        mezcla_d        = mezcla_q;
        adc_inicio_d    = 1'b0;
        filtro_inicio_d = 1'b0;
        valida_d        = 1'b0;
        sobre_d         = sobre_q;
        suma            = acc_q + {{2{bus.filtro_salida[ANCHO-1]}}, bus.filtro_salida};

        // A tick that finds a sequence in flight is dropped, only flagged.
        if (tick && (estado_q != ESPERA)) begin
            sobre_d = 1'b1;
        end

        case (estado_q)
            ESPERA: begin
                if (tick) begin
                    adc_inicio_d = 1'b1;
                    estado_d     = CONVIERTE;
                end
            end
            CONVIERTE: begin
                if (bus.adc_listo) begin
                    entrada_d       = ANCHO'({bus.salidaADC, 2'b00}) - OFFSET_ADC;
                    k_d             = 2'd0;
                    acc_d           = '0;
                    filtro_inicio_d = 1'b1;
                    estado_d        = AGUARDA;
                end
            end
            AGUARDA: begin
                if (bus.filtro_fin) begin
                    acc_d = suma;
                    if (k_q < BANDA_ULT) begin
                        k_d             = k_q + 2'd1;
                        filtro_inicio_d = 1'b1;
                    end else begin
                        // Clamp only the final sum so intermediate overshoot
                        // can be cancelled by later bands.
                        if (suma > SAT_MAX) begin
                            mezcla_d = SAT_MAX[ANCHO-1:0];
                        end else if (suma < SAT_MIN) begin
                            mezcla_d = SAT_MIN[ANCHO-1:0];
                        end else begin
                            mezcla_d = suma[ANCHO-1:0];
                        end
                        valida_d = 1'b1;
                        estado_d = ESPERA;
                    end
                end
            end
            default: estado_d = ESPERA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q        <= ESPERA;
            cnt_q           <= '0;
            k_q             <= 2'd0;
            acc_q           <= '0;
            entrada_q       <= '0;
            mezcla_q        <= '0;
            adc_inicio_q    <= 1'b0;
            filtro_inicio_q <= 1'b0;
            valida_q        <= 1'b0;
            sobre_q         <= 1'b0;
        end else begin
            estado_q        <= estado_d;
            cnt_q           <= cnt_d;
            k_q             <= k_d;
            acc_q           <= acc_d;
            entrada_q       <= entrada_d;
            mezcla_q        <= mezcla_d;
            adc_inicio_q    <= adc_inicio_d;
            filtro_inicio_q <= filtro_inicio_d;
            valida_q        <= valida_d;
            sobre_q         <= sobre_d;
        end
    end

    assign bus.adc_inicio     = adc_inicio_q;
    assign bus.filtro_inicio  = filtro_inicio_q;
    assign bus.filtro_banda   = k_q;
    assign bus.filtro_entrada = entrada_q;
    assign bus.salida_mezcla  = mezcla_q;
    assign bus.salida_valida  = valida_q;
    assign bus.sobrecarga     = sobre_q;

endmodule
